// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Groups the signals that pass between the ID-stage hazard controller and the
// rest of the pipeline.
//   master : pipeline side. Drives the ID/EX operand fields, the branch
//            resolution and the data-memory handshake. Receives the bubble,
//            stall, flush, freeze and error controls.
//   slave  : hazard_ctrl side, with the opposite directions.
// Inputs into the controller:
//   IFID_Op_i[6:0], IFID_RS1_i[4:0], IFID_RS2_i[4:0], IDEX_MemRead_i,
//   IDEX_RD_i[4:0], Branch_taken_i, DMem_req_i, DMem_ack_i
// Outputs from the controller:
//   Noop_o, Stall_o, PCWrite_o, Flush_o, MemStall_o, Err_o
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;
  logic [6:0] IFID_Op_i;
  logic [4:0] IFID_RS1_i;
  logic [4:0] IFID_RS2_i;
  logic       IDEX_MemRead_i;
  logic [4:0] IDEX_RD_i;
  logic       Branch_taken_i;
  logic       DMem_req_i;
  logic       DMem_ack_i;
  logic       Noop_o;
  logic       Stall_o;
  logic       PCWrite_o;
  logic       Flush_o;
  logic       MemStall_o;
  logic       Err_o;

  modport master (
    output IFID_Op_i, IFID_RS1_i, IFID_RS2_i, IDEX_MemRead_i, IDEX_RD_i,
           Branch_taken_i, DMem_req_i, DMem_ack_i,
    input  Noop_o, Stall_o, PCWrite_o, Flush_o, MemStall_o, Err_o
  );

  modport slave (
    input  IFID_Op_i, IFID_RS1_i, IFID_RS2_i, IDEX_MemRead_i, IDEX_RD_i,
           Branch_taken_i, DMem_req_i, DMem_ack_i,
    output Noop_o, Stall_o, PCWrite_o, Flush_o, MemStall_o, Err_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard and stall controller for the 5-stage RISC-V pipeline. Injects a
// bubble on a load-use hazard, freezes the whole pipe while a data-memory
// access is outstanding, and flushes IF/ID on a taken branch resolved in ID.
// Every control output is combinational from the inputs and the current
// state; only the wait FSM, the wait counter and the error flag are stored.
//
// Parameters:
//   TIMEOUT : MEM_WAIT cycles without ack before Err_o sets (default 255)
//   CNT_W   : wait counter width, 2**CNT_W must exceed TIMEOUT (default 8)
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-low reset
//   bus     : hazard_ctrl_if.slave (ID/EX operands, branch, memory handshake
//             in; Noop/Stall/PCWrite/Flush/MemStall/Err out)
// Optional feature, macro HAZARD_PERF_CNT_EN:
//   StallCnt_o[31:0] : saturating count of cycles with Stall_o=1
//   FlushCnt_o[31:0] : saturating count of cycles with Flush_o=1
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]   StallCnt_o,
  output logic [31:0]   FlushCnt_o
`endif
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  logic uses_rs1;
  logic uses_rs2;
  logic lu;
  logic mem_stall;
  logic noop;
  logic stall;
  logic pc_write;
  logic flush;

  // -------------------------------------------------------------------------
  // Load-use detection. Only the opcodes that actually read a source operand
  // may match; x0 is hard-wired zero so it never carries a dependency.
  // -------------------------------------------------------------------------
  always_comb begin
    uses_rs1 = bus.IFID_Op_i inside {7'd51, 7'd19, 7'd3, 7'd35, 7'd99};
    uses_rs2 = bus.IFID_Op_i inside {7'd51, 7'd35, 7'd99};
    lu = bus.IDEX_MemRead_i && (bus.IDEX_RD_i != 5'd0) &&
         ((uses_rs1 && (bus.IDEX_RD_i == bus.IFID_RS1_i)) ||
          (uses_rs2 && (bus.IDEX_RD_i == bus.IFID_RS2_i)));
  end

  // A request acked in the same cycle never stalls; otherwise the pipe is
  // frozen from the request cycle until (not including) the ack cycle.
  always_comb begin
    mem_stall = ((state_q == RUN) && bus.DMem_req_i && !bus.DMem_ack_i) ||
                ((state_q == MEM_WAIT) && !bus.DMem_ack_i);
  end

  // -------------------------------------------------------------------------
  // Wait FSM, timeout counter and sticky error flag.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      RUN: begin
        if (bus.DMem_req_i && !bus.DMem_ack_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (bus.DMem_ack_i) begin
          state_d = RUN;
        end else begin
          if (wait_cnt_q != TIMEOUT_C) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
          // The FSM keeps waiting after a timeout; only the flag records it.
          if (wait_cnt_d == TIMEOUT_C) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output priority: memory freeze > load-use bubble > branch flush > run.
  // A bubble is pointless while the whole pipe is frozen, and a branch that
  // coincides with a load-use is ignored because its operands are stale.
  // While reset is held the decoder is forced to emit NOPs and the PC holds.
  // -------------------------------------------------------------------------
  always_comb begin
    noop     = 1'b0;
    stall    = 1'b0;
    pc_write = 1'b1;
    flush    = 1'b0;
    if (!rst_i) begin
      noop     = 1'b1;
      pc_write = 1'b0;
    end else if (mem_stall) begin
      stall    = 1'b1;
      pc_write = 1'b0;
    end else if (lu) begin
      noop     = 1'b1;
      stall    = 1'b1;
      pc_write = 1'b0;
    end else if (bus.Branch_taken_i) begin
      flush    = 1'b1;
    end
  end

  assign bus.Noop_o     = noop;
  assign bus.Stall_o    = stall;
  assign bus.PCWrite_o  = pc_write;
  assign bus.Flush_o    = flush;
  assign bus.MemStall_o = rst_i && mem_stall;
  assign bus.Err_o      = err_q;

`ifdef HAZARD_PERF_CNT_EN
  // -------------------------------------------------------------------------
  // Saturating performance counters.
  // -------------------------------------------------------------------------
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
`endif

endmodule
